// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RISC-V controller:
// FSM states, opcodes, ALU op/control codes and datapath select codes.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BEQ,
        S_JAL
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    localparam logic [1:0] SRCB_WD    = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU decoder: maps ALUOp plus instruction funct fields to ALUControl.
// Subtract is only selected for R-type (OP[5]=1) with funct7 set.
module alu_decoder
    import multicycle_controller_pkg::*;
(
    input  aluop_t     i_aluop,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7,
    input  logic       i_op5,
    output logic [2:0] o_alucontrol
);

    always_comb begin
        o_alucontrol = ALU_ADD;
        case (i_aluop)
            ALUOP_ADD: o_alucontrol = ALU_ADD;
            ALUOP_SUB: o_alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    3'b000:  o_alucontrol = (i_op5 && i_funct7) ? ALU_SUB : ALU_ADD;
                    3'b010:  o_alucontrol = ALU_SLT;
                    3'b110:  o_alucontrol = ALU_OR;
                    3'b111:  o_alucontrol = ALU_AND;
                    default: o_alucontrol = ALU_ADD;
                endcase
            end
            default: o_alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore main FSM for a multicycle RISC-V core (lw/sw/R/I/beq/jal),
// with ImmSrc decode and the ALU decoder instance.
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic [6:0] OP,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       IllegalInstr
);

    state_t r_state;
    state_t w_next;
    aluop_t w_aluop;
    logic   w_pcupdate;
    logic   w_branch;
    logic   w_irwrite;
    logic   w_regwrite;
    logic   w_memwrite;
    logic   w_illegal;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next     = S_FETCH;
        w_aluop    = ALUOP_ADD;
        w_pcupdate = 1'b0;
        w_branch   = 1'b0;
        w_irwrite  = 1'b0;
        w_regwrite = 1'b0;
        w_memwrite = 1'b0;
        w_illegal  = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_WD;
        case (r_state)
            S_FETCH: begin
                w_next     = S_DECODE;
                w_irwrite  = 1'b1;
                w_pcupdate = 1'b1;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALURES;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (OP)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXECUTER;
                    OP_I:         w_next = S_EXECUTEI;
                    OP_BEQ:       w_next = S_BEQ;
                    OP_JAL:       w_next = S_JAL;
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                w_next  = (OP == OP_SW) ? S_MEMWRITE : S_MEMREAD;
                ALUSrcA = SRCA_A;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                w_next = S_MEMWB;
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc  = RES_DATA;
                w_regwrite = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc     = 1'b1;
                w_memwrite = 1'b1;
            end
            S_EXECUTER: begin
                w_next  = S_ALUWB;
                ALUSrcA = SRCA_A;
                w_aluop = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                w_next  = S_ALUWB;
                ALUSrcA = SRCA_A;
                ALUSrcB = SRCB_IMM;
                w_aluop = ALUOP_FUNCT;
            end
            S_ALUWB: w_regwrite = 1'b1;
            S_BEQ: begin
                ALUSrcA  = SRCA_A;
                w_aluop  = ALUOP_SUB;
                w_branch = 1'b1;
            end
            S_JAL: begin
                w_next     = S_ALUWB;
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                w_pcupdate = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Enables are gated by RESET so nothing writes while held in reset.
    assign PCWrite      = RESET & (w_pcupdate | (w_branch & Zero));
    assign IRWrite      = RESET & w_irwrite;
    assign RegWrite     = RESET & w_regwrite;
    assign MemWrite     = RESET & w_memwrite;
    assign IllegalInstr = RESET & w_illegal;

    always_comb begin
        ImmSrc = IMM_I;
        case (OP)
            OP_SW:   ImmSrc = IMM_S;
            OP_BEQ:  ImmSrc = IMM_B;
            OP_JAL:  ImmSrc = IMM_J;
            default: ImmSrc = IMM_I;
        endcase
    end

    alu_decoder u_alu_decoder (
        .i_aluop      (w_aluop),
        .i_funct3     (funct3),
        .i_funct7     (funct7),
        .i_op5        (OP[5]),
        .o_alucontrol (ALUControl)
    );

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have ports: CLK  input  1  system clock, rising-edge active.
REQ-002 SHALL have ports: RESET  input  1  asynchronous, active-low reset.
REQ-003 SHALL have the following datapath-facing ports:
- OP  input  7  opcode field
- funct3  input  3  instruction bits 14:12
- funct7  input  1  instruction bit 30
- Zero  input  1  ALU zero flag
REQ-004 SHALL have the following control outputs:
- PCWrite  output  1  PC register enable
- AdrSrc  output  1  memory address select: 0=PC, 1=Result
- MemWrite  output  1  memory write enable
- IRWrite  output  1  instruction and OldPC register enable
- RegWrite  output  1  register file write enable
REQ-005 SHALL have the following select and decode outputs:
- ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  output  2  00=PC, 01=OldPC, 10=A
- ALUSrcB  output  2  00=WriteData, 01=ImmExt, 10=constant 4
- ImmSrc  output  2  00=I, 01=S, 10=B, 11=J
- ALUControl  output  3  000=add, 001=sub, 010=and, 011=or, 101=slt
- IllegalInstr  output  1  unsupported opcode pulse

Function
REQ-006 SHALL implement a Moore main FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ and JAL; state advances on the CLK rising edge.
REQ-007 SHALL use these DECODE transitions:
- OP=0000011 (lw) or 0100011 (sw) -> MEMADR
- OP=0110011 -> EXECUTER
- OP=0010011 -> EXECUTEI
- OP=1100011 -> BEQ
- OP=1101111 -> JAL
- any other OP -> FETCH
REQ-008 SHALL use these other transitions:
- FETCH -> DECODE
- MEMADR -> MEMREAD for lw, MEMWRITE for sw
- MEMREAD -> MEMWB
- EXECUTER, EXECUTEI and JAL -> ALUWB
- MEMWB, MEMWRITE, ALUWB and BEQ -> FETCH
REQ-009 SHALL drive these per-state outputs; any unlisted output is 0:
- FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=add, ResultSrc=10, PCUpdate=1
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=add
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=add
- MEMREAD: ResultSrc=00, AdrSrc=1
- MEMWB: ResultSrc=01, RegWrite=1
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=funct
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=funct
- ALUWB: ResultSrc=00, RegWrite=1
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=sub, ResultSrc=00, Branch=1
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=add, ResultSrc=00, PCUpdate=1
REQ-010 SHALL compute PCWrite = PCUpdate OR (Branch AND Zero), combinationally, in the same cycle as Zero.
REQ-011 SHALL decode ALUControl as follows:
- ALUOp=add -> 000
- ALUOp=sub -> 001
- ALUOp=funct, funct3=000 -> 001 if OP[5]=1 and funct7=1, else 000
- ALUOp=funct, funct3=010 -> 101
- ALUOp=funct, funct3=110 -> 011
- ALUOp=funct, funct3=111 -> 010
- ALUOp=funct, any other funct3 -> 000
REQ-012 SHALL decode ImmSrc combinationally from OP in every state: lw/I-type=00, sw=01, beq=10, jal=11, other=00.
REQ-013 SHALL give these instruction latencies: lw 5 cycles, sw/R/I/jal 4 cycles, beq 3 cycles.
REQ-014 SHALL assert IllegalInstr for exactly the DECODE cycle of an unsupported OP, with no write enable asserted for that instruction.
REQ-015 SHALL assert MemWrite and RegWrite in at most one cycle per instruction.

Reset
REQ-016 SHALL force the state to FETCH asynchronously when RESET=0, including mid-instruction.
REQ-017 SHALL hold PCWrite, IRWrite, RegWrite, MemWrite and IllegalInstr at 0 while RESET=0.
REQ-018 SHALL drive all other outputs to their FETCH values while RESET=0.
REQ-019 SHALL execute a full FETCH cycle on the first rising edge after RESET returns to 1.

Structure
REQ-020 SHALL take the following from a shared package: state encoding, opcode constants, ALUControl codes, ALUOp codes, and the ResultSrc/ALUSrcA/ALUSrcB/ImmSrc select codes.
REQ-021 SHALL instantiate one sub-module, alu_decoder (ALUOp, funct3, funct7, OP[5] -> ALUControl); the FSM and the ImmSrc decode stay in multicycle_controller.

Verification
REQ-022 SHALL verify R-type sub: OP=0110011, funct3=000, funct7=1 -> FETCH, DECODE, EXECUTER, ALUWB; ALUControl=001 in EXECUTER; RegWrite=1 only in ALUWB.
REQ-023 SHALL verify lw: OP=0000011 -> 5 cycles; AdrSrc=1 in MEMREAD; ResultSrc=01 and RegWrite=1 in MEMWB; ImmSrc=00.
REQ-024 SHALL verify sw: OP=0100011 -> MemWrite=1 for exactly one cycle (MEMWRITE), ImmSrc=01, RegWrite never 1.
REQ-025 SHALL verify beq in both Zero cases: Zero=1 in BEQ -> PCWrite=1; Zero=0 -> PCWrite=0; either case returns to FETCH after 3 cycles.
REQ-026 SHALL verify an illegal opcode: OP=1111111 -> IllegalInstr=1 in DECODE only, next state FETCH, no write enable asserted.
REQ-027 SHALL verify reset mid-instruction: RESET=0 during MEMREAD -> state FETCH immediately, all write enables 0; after release, IRWrite=1 and PCWrite=1 on the first cycle.
